// File: rtl/microsequencer_pkg.sv
// -----------------------------------------------------------------------------
// microsequencer_pkg
//
// Shared control-unit definitions used by the microsequencer and its
// next-state selector:
//   - ns_code_e           : the 3-bit sequencing codes carried in field `n`
//                           of every control word
//   - STATE_W             : microstate address width (microstore address)
//   - FETCH_STATE         : entry point of the instruction fetch routine
//   - DEFAULT_FAULT_STATE : microroutine that handles bus and sequencing faults
//   - WCNT_W              : width of the memory-wait counter
// -----------------------------------------------------------------------------
package microsequencer_pkg;

    localparam int STATE_W = 10;
    localparam int WCNT_W  = 8;

    localparam logic [STATE_W-1:0] FETCH_STATE         = 10'd0;
    localparam logic [STATE_W-1:0] DEFAULT_FAULT_STATE = 10'd43;

    typedef enum logic [2:0] {
        NS_DECODE      = 3'b000,  // jump to the encoder's first execute state
        NS_FETCH       = 3'b001,  // restart the fetch routine
        NS_BRANCH      = 3'b010,  // unconditional branch to cr
        NS_INCR        = 3'b011,  // fall through to the next state
        NS_WAIT_INCR   = 3'b100,  // hold until moc, then fall through
        NS_COND_BRANCH = 3'b101,  // branch to cr when cond ^ inv
        NS_WAIT_BRANCH = 3'b110,  // hold until moc, then branch to cr
        NS_ILLEGAL     = 3'b111   // unused encoding
    } ns_code_e;

    // Codes that stall on the memory handshake.
    function automatic logic is_wait_code(input logic [2:0] code);
        return (code == NS_WAIT_INCR) || (code == NS_WAIT_BRANCH);
    endfunction

endpackage : microsequencer_pkg

// File: rtl/microsequencer_ns_mux.sv
// -----------------------------------------------------------------------------
// microsequencer_ns_mux
//
// Purely combinational selection of the next microstate address from the
// sequencing fields of the current control word. A MOC timeout overrides
// every sequencing code.
//
// Ports:
//   n             in  3        sequencing code
//   inv           in  1        condition inverter for the conditional branch
//   moc           in  1        memory operation complete
//   cond          in  1        branch condition result
//   timeout       in  1        memory wait has exhausted its budget
//   cr            in  STATE_W  branch target from the control word
//   encoder_state in  STATE_W  first execute state from the encoder
//   current_state in  STATE_W  registered current microstate
//   next_state    out STATE_W  selected next microstate
// -----------------------------------------------------------------------------
module microsequencer_ns_mux
    import microsequencer_pkg::*;
#(
    parameter int                  STATE_W     = microsequencer_pkg::STATE_W,
    parameter logic [STATE_W-1:0]  FAULT_STATE = STATE_W'(DEFAULT_FAULT_STATE)
) (
    input  logic [2:0]          n,
    input  logic                inv,
    input  logic                moc,
    input  logic                cond,
    input  logic                timeout,
    input  logic [STATE_W-1:0]  cr,
    input  logic [STATE_W-1:0]  encoder_state,
    input  logic [STATE_W-1:0]  current_state,
    output logic [STATE_W-1:0]  next_state
);

    logic [STATE_W-1:0] incr;

    always_comb begin
        // Truncation to STATE_W bits gives the modulo wrap from the top state.
        incr       = current_state + STATE_W'(1);
        next_state = STATE_W'(FETCH_STATE);

        case (ns_code_e'(n))
            NS_DECODE:      next_state = encoder_state;
            NS_FETCH:       next_state = STATE_W'(FETCH_STATE);
            NS_BRANCH:      next_state = cr;
            NS_INCR:        next_state = incr;
            NS_WAIT_INCR:   next_state = moc ? incr : current_state;
            NS_COND_BRANCH: next_state = (cond ^ inv) ? cr : incr;
            NS_WAIT_BRANCH: next_state = moc ? cr : current_state;
            NS_ILLEGAL:     next_state = STATE_W'(FETCH_STATE);
            default:        next_state = STATE_W'(FETCH_STATE);
        endcase

        // Timeout is only raised while moc is low, so a completing memory
        // operation always wins over the fault.
        if (timeout) begin
            next_state = FAULT_STATE;
        end
    end

endmodule : microsequencer_ns_mux

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
//
// Next-state address generator feeding the microstore. Holds the current
// microstate, counts memory-wait cycles and raises one-cycle pulses on a
// MOC timeout or an illegal sequencing code. next_state is combinational so
// the microstore and this block's state register capture on the same edge.
//
// Ports:
//   clk           in  1        rising-edge clock
//   reset         in  1        asynchronous active-high reset
//   n             in  3        sequencing code from the current control word
//   inv           in  1        condition inverter for the conditional branch
//   cr            in  STATE_W  branch target from the current control word
//   encoder_state in  STATE_W  first execute state from the encoder
//   moc           in  1        memory operation complete
//   cond          in  1        branch condition result
//   next_state    out STATE_W  combinational address to the microstore
//   current_state out STATE_W  registered current microstate
//   bus_fault     out 1        one-cycle pulse after a MOC timeout edge
//   illegal_ns    out 1        one-cycle pulse after an edge with n = 111
// -----------------------------------------------------------------------------
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int                  STATE_W     = microsequencer_pkg::STATE_W,
    parameter int                  MOC_TIMEOUT = 15,
    parameter logic [STATE_W-1:0]  FAULT_STATE = STATE_W'(DEFAULT_FAULT_STATE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          n,
    input  logic                inv,
    input  logic [STATE_W-1:0]  cr,
    input  logic [STATE_W-1:0]  encoder_state,
    input  logic                moc,
    input  logic                cond,
    output logic [STATE_W-1:0]  next_state,
    output logic [STATE_W-1:0]  current_state,
    output logic                bus_fault,
    output logic                illegal_ns
);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] current_state_q, current_state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               bus_fault_q, bus_fault_d;
    logic               illegal_ns_q, illegal_ns_d;

    logic               waiting;
    logic               timeout;
    logic [STATE_W-1:0] mux_state;

    microsequencer_ns_mux #(
        .STATE_W     (STATE_W),
        .FAULT_STATE (FAULT_STATE)
    ) u_ns_mux (
        .n             (n),
        .inv           (inv),
        .moc           (moc),
        .cond          (cond),
        .timeout       (timeout),
        .cr            (cr),
        .encoder_state (encoder_state),
        .current_state (current_state_q),
        .next_state    (mux_state)
    );

    always_comb begin
        // moc is only meaningful inside a wait code.
        waiting = is_wait_code(n) && !moc;
        timeout = waiting && (wcnt_q == WCNT_LAST);

        // The timeout edge clears the counter along with every non-wait edge.
        wcnt_d = (waiting && !timeout) ? wcnt_q + WCNT_W'(1) : '0;

        current_state_d = mux_state;
        bus_fault_d     = timeout;
        illegal_ns_d    = (n == NS_ILLEGAL);

        // The microstore must see state 0 while reset is held, not the
        // address computed from whatever the control word happens to carry.
        next_state = reset ? STATE_W'(FETCH_STATE) : mux_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state_q <= STATE_W'(FETCH_STATE);
            wcnt_q          <= '0;
            bus_fault_q     <= 1'b0;
            illegal_ns_q    <= 1'b0;
        end else begin
            current_state_q <= current_state_d;
            wcnt_q          <= wcnt_d;
            bus_fault_q     <= bus_fault_d;
            illegal_ns_q    <= illegal_ns_d;
        end
    end

    assign current_state = current_state_q;
    assign bus_fault     = bus_fault_q;
    assign illegal_ns    = illegal_ns_q;

endmodule : microsequencer

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
//
// Directed testbench for microsequencer with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are compared
// while the clock is away from its rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_microsequencer;

    logic       clk;
    logic       reset;
    logic [2:0] n;
    logic       inv;
    logic [9:0] cr;
    logic [9:0] encoder_state;
    logic       moc;
    logic       cond;
    logic [9:0] next_state;
    logic [9:0] current_state;
    logic       bus_fault;
    logic       illegal_ns;

    int err_cnt;
    int chk_cnt;

    microsequencer dut (
        .clk           (clk),
        .reset         (reset),
        .n             (n),
        .inv           (inv),
        .cr            (cr),
        .encoder_state (encoder_state),
        .moc           (moc),
        .cond          (cond),
        .next_state    (next_state),
        .current_state (current_state),
        .bus_fault     (bus_fault),
        .illegal_ns    (illegal_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put the block into a known state via an unconditional branch.
    task automatic load_state(input logic [9:0] s);
        n   = 3'b010;
        cr  = s;
        moc = 1'b0;
        step();
        check_eq("load_state", current_state, s);
    endtask

    initial begin
        err_cnt       = 0;
        chk_cnt       = 0;
        reset         = 1'b1;
        n             = 3'b001;
        inv           = 1'b0;
        cr            = '0;
        encoder_state = '0;
        moc           = 1'b0;
        cond          = 1'b0;

        // Power-up reset.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cs", current_state, 0);
        check_eq("rst_ns", next_state, 0);
        check_eq("rst_bf", bus_fault, 0);
        check_eq("rst_il", illegal_ns, 0);
        reset = 1'b0;
        step();

        // Reset asserted mid-wait with state 12 and wcnt 5.
        load_state(10'd12);
        n   = 3'b100;
        moc = 1'b0;
        repeat (5) step();
        check_eq("midwait_cs", current_state, 12);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_ns", next_state, 0);
        check_eq("async_rst_cs", current_state, 0);
        n = 3'b001;
        step();
        check_eq("rst_hold_cs", current_state, 0);
        reset = 1'b0;
        step();
        check_eq("post_rst_fetch", current_state, 0);

        // Sequencing chain.
        n = 3'b011;
        #1;
        check_eq("incr_ns", next_state, 1);
        step();
        check_eq("incr_cs", current_state, 1);
        n             = 3'b000;
        encoder_state = 10'd20;
        step();
        check_eq("decode_cs", current_state, 20);
        n  = 3'b010;
        cr = 10'd41;
        step();
        check_eq("branch_cs", current_state, 41);
        load_state(10'd1023);
        n = 3'b011;
        #1;
        check_eq("wrap_ns", next_state, 0);
        step();
        check_eq("wrap_cs", current_state, 0);

        // moc is ignored outside the wait codes.
        n   = 3'b011;
        moc = 1'b1;
        step();
        check_eq("moc_ignored", current_state, 1);

        // Conditional branch from state 25.
        load_state(10'd25);
        n  = 3'b101;
        cr = 10'd30;
        cond = 1'b1; inv = 1'b0; #1;
        check_eq("cb_c1_i0", next_state, 30);
        cond = 1'b1; inv = 1'b1; #1;
        check_eq("cb_c1_i1", next_state, 26);
        cond = 1'b0; inv = 1'b1; #1;
        check_eq("cb_c0_i1", next_state, 30);
        cond = 1'b0; inv = 1'b0; #1;
        check_eq("cb_c0_i0", next_state, 26);
        step();
        check_eq("cb_cs", current_state, 26);
        inv = 1'b0;

        // Wait-increment: moc low 4 cycles, then high.
        load_state(10'd3);
        n   = 3'b100;
        moc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("wi_hold", current_state, 3);
            check_eq("wi_no_bf", bus_fault, 0);
        end
        moc = 1'b1;
        #1;
        check_eq("wi_ns", next_state, 4);
        step();
        check_eq("wi_cs", current_state, 4);
        check_eq("wi_bf", bus_fault, 0);

        // Wait-branch to cr=0.
        load_state(10'd3);
        n   = 3'b110;
        cr  = 10'd0;
        moc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("wb_hold", current_state, 3);
        end
        moc = 1'b1;
        step();
        check_eq("wb_cs", current_state, 0);
        check_eq("wb_bf", bus_fault, 0);

        // Timeout: moc never high, fault on the 15th edge.
        load_state(10'd3);
        n   = 3'b100;
        moc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("to_hold", current_state, 3);
            check_eq("to_no_bf", bus_fault, 0);
        end
        check_eq("to_ns", next_state, 43);
        step();
        check_eq("to_cs", current_state, 43);
        check_eq("to_bf", bus_fault, 1);
        n = 3'b001;
        step();
        check_eq("to_bf_pulse", bus_fault, 0);
        check_eq("to_fetch", current_state, 0);

        // moc rises on the 15th cycle: moc wins over the timeout.
        load_state(10'd3);
        n   = 3'b100;
        moc = 1'b0;
        repeat (14) step();
        check_eq("late_hold", current_state, 3);
        moc = 1'b1;
        #1;
        check_eq("late_ns", next_state, 4);
        step();
        check_eq("late_cs", current_state, 4);
        check_eq("late_bf", bus_fault, 0);

        // Illegal code, twice back to back.
        load_state(10'd7);
        n = 3'b111;
        #1;
        check_eq("ill_ns", next_state, 0);
        check_eq("ill_pre", illegal_ns, 0);
        step();
        check_eq("ill_cs", current_state, 0);
        check_eq("ill_pulse1", illegal_ns, 1);
        step();
        check_eq("ill_pulse2", illegal_ns, 1);
        n = 3'b001;
        step();
        check_eq("ill_clear", illegal_ns, 0);
        check_eq("ill_bf", bus_fault, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_microsequencer
